// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO register pair.
//   One radix-2 step per cycle over WIDTH cycles. Signed operands are reduced to
//   magnitudes in PREP and the signs are reapplied in FIX. The pipeline is held via
//   stall while the op runs. done / hilo_we pulse for one cycle in DONE.
// Ports:
//   clk, reset (async, active low)
//   start, op[1:0], cancel, src_a, src_b : request from EX (sampled only in IDLE)
//   busy, stall, done                   : status / pipeline hold
//   hi_out, lo_out, hilo_we             : HI/LO write data and strobes
module muldiv_seq #(
  parameter int WIDTH       = 32,
  parameter bit BYPASS_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       hilo_we
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
  state_t state, state_nx;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_b;
  logic [2*WIDTH-1:0] acc;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]      cnt;
  logic               sa, sb, dz;

  // decode only from the captured op
  logic is_div, is_signed, a_neg, b_neg, bypass;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  // -0x80..0 wraps to 0x80..0, which is the correct magnitude read as unsigned
  assign abs_a     = a_neg ? -a_q : a_q;
  assign abs_b     = b_neg ? -b_q : b_q;
  assign bypass    = BYPASS_ZERO && !is_div && (a_q == '0 || b_q == '0);

  // multiply step: conditional add of the multiplicand into the upper half, then shift right
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_nx  = {add_sum, acc[WIDTH-1:1]};

  // restoring divide step. rem < divisor, so shl < 2*divisor and diff[WIDTH] is a clean borrow.
  logic [WIDTH:0]     shl, diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_nx;
  assign shl    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff   = shl - {1'b0, mag_b};
  assign q_bit  = ~diff[WIDTH];
  assign div_nx = {(q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};

  // sign fix-up
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];
  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (dz) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = sa ? -rem : rem;
      fix_lo = (sa ^ sb) ? -quo : quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !cancel) state_nx = S_PREP;
      S_PREP:  if (cancel) state_nx = S_IDLE;
               else if (bypass) state_nx = S_FIX;
               else state_nx = S_CALC;
      S_CALC:  if (cancel) state_nx = S_IDLE;
               else if (cnt == CW'(1)) state_nx = S_FIX;
      S_FIX:   state_nx = cancel ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && !cancel) begin
          op_q <= op;
          a_q  <= src_a;
          b_q  <= src_b;
        end
        S_PREP: begin
          sa    <= a_neg;
          sb    <= b_neg;
          dz    <= is_div && (b_q == '0);
          mag_b <= abs_b;
          acc   <= bypass ? '0 : {{WIDTH{1'b0}}, abs_a};
          cnt   <= CW'(WIDTH);
        end
        S_CALC: begin
          acc <= is_div ? div_nx : mul_nx;
          cnt <= cnt - CW'(1);
        end
        // results stay put until the next op that survives FIX
        S_FIX: if (!cancel) begin
          hi_out <= fix_hi;
          lo_out <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign hilo_we = {done, done};
  // the IDLE request term is gated so stall stays low while reset is held
  assign stall   = (reset && state == S_IDLE && start && !cancel) ||
                   state == S_PREP || state == S_CALC || state == S_FIX;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, stall, done;
  logic [31:0] hi_out, lo_out;
  logic [1:0]  hilo_we;
  int n_cmp = 0, n_err = 0, done_cnt = 0;

  muldiv_seq #(.WIDTH(32), .BYPASS_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .src_a(src_a), .src_b(src_b), .busy(busy), .stall(stall), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .hilo_we(hilo_we));

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam int NV = 10;
  localparam logic [1:0]  V_OP [NV] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2};
  localparam logic [31:0] V_A  [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                                        32'd0, 32'd5, 32'd7, 32'd7, 32'hFFFFFFF9};
  localparam logic [31:0] V_B  [NV] = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF,
                                        32'h1234, 32'd0, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE};
  localparam logic [31:0] V_HI [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'd0,
                                        32'd0, 32'd5, 32'd0, 32'd1, 32'hFFFFFFFF};
  localparam logic [31:0] V_LO [NV] = '{32'hFFFFFFF1, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                                        32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFD, 32'd3};
  localparam int          V_LAT[NV] = '{35, 35, 35, 35, 35, 3, 35, 3, 35, 35};

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // behavioural reference: plain 64-bit arithmetic
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint p, q, r;
    logic [63:0] u;
    case (o)
      2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
      default:
        if (b == 0) begin hi = a; lo = '1; end
        else if (o == 2'd2) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          hi = r[31:0]; lo = q[31:0];
        end else begin hi = a % b; lo = a / b; end
    endcase
  endtask

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (!o[1] && (a == 0 || b == 0)) ? 3 : 35;
  endfunction

  // Drives one op starting in the current cycle (cycle 0); returns at the negedge of the
  // cycle after done. lat = cycle of done (-1 if it never came).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic [1:0] we,
                       output int lat, output int stall_bad, output logic tail_bad);
    op = o; src_a = a; src_b = b; start = 1'b1;
    lat = -1; stall_bad = 0; hi = '0; lo = '0; we = '0;
    #1;
    if (stall !== 1'b1) stall_bad++;
    next_cyc();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c; hi = hi_out; lo = lo_out; we = hilo_we;
        if (stall !== 1'b0) stall_bad++;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
      next_cyc();
    end
    @(negedge clk);
    tail_bad = (done !== 1'b0) || (hilo_we !== 2'b00) || (busy !== 1'b0);
  endtask

  task automatic test_reset();
    start = 1'b1; op = 2'd2; src_a = 32'd9; src_b = 32'd3;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, stall, done, hilo_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got busy/stall/done/we=%b want 00000", {busy, stall, done, hilo_we});
    end
    n_cmp++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL reset_data got %h_%h want 0_0", hi_out, lo_out);
    end
    start = 1'b0;
    next_cyc(); reset = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      n_err++; $display("FAIL reset_release got busy=%b done_cnt=%0d want 0/0", busy, done_cnt);
    end
  endtask

  task automatic test_directed();
    logic [31:0] hi, lo; logic [1:0] we; int lat, sbad; logic tb;
    for (int i = 0; i < NV; i++) begin
      next_cyc();
      do_op(V_OP[i], V_A[i], V_B[i], hi, lo, we, lat, sbad, tb);
      n_cmp++;
      if (hi !== V_HI[i] || lo !== V_LO[i]) begin
        n_err++; $display("FAIL directed%0d result got %h_%h want %h_%h", i, hi, lo, V_HI[i], V_LO[i]);
      end
      n_cmp++;
      if (lat != V_LAT[i]) begin
        n_err++; $display("FAIL directed%0d latency got %0d want %0d", i, lat, V_LAT[i]);
      end
      n_cmp++;
      if (we !== 2'b11 || tb !== 1'b0) begin
        n_err++; $display("FAIL directed%0d strobe got we=%b tail_bad=%b want 11/0", i, we, tb);
      end
      n_cmp++;
      if (sbad != 0) begin
        n_err++; $display("FAIL directed%0d stall_profile got %0d bad cycles want 0", i, sbad);
      end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] hi, lo, hold_hi, hold_lo; logic [1:0] we; int lat, sbad, d0; logic tb;
    next_cyc();
    start = 1'b1; cancel = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd3; #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL start_cancel_stall got %b want 0", stall); end
    next_cyc(); start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_cancel_busy got %b want 0", busy); end
    hold_hi = hi_out; hold_lo = lo_out; d0 = done_cnt;
    next_cyc(); start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;  // cycle 0
    next_cyc(); start = 1'b0;                                            // cycle 1
    repeat (9) next_cyc();                                               // cycle 10
    cancel = 1'b1;
    next_cyc(); cancel = 1'b0;                                           // cycle 11
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      n_err++; $display("FAIL cancel_calc got busy=%b dones=%0d want 0/%0d", busy, done_cnt, d0);
    end
    n_cmp++;
    if (hi_out !== hold_hi || lo_out !== hold_lo) begin
      n_err++; $display("FAIL cancel_hold got %h_%h want %h_%h", hi_out, lo_out, hold_hi, hold_lo);
    end
    next_cyc();                                                          // cycle 12
    do_op(2'd0, 32'd2, 32'd3, hi, lo, we, lat, sbad, tb);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd6 || lat != 35) begin
      n_err++; $display("FAIL after_cancel got %h_%h lat=%0d want 0_6 lat=35", hi, lo, lat);
    end
  endtask

  task automatic test_cancel_fix_done();
    logic [31:0] hi, lo; logic [1:0] we; int lat, sbad, d0; logic tb;
    next_cyc();
    do_op(2'd1, 32'h12345678, 32'h10, hi, lo, we, lat, sbad, tb);
    n_cmp++;
    if (hi !== 32'd1 || lo !== 32'h23456780) begin
      n_err++; $display("FAIL multu_shift got %h_%h want 00000001_23456780", hi, lo);
    end
    d0 = done_cnt;
    next_cyc(); start = 1'b1; op = 2'd0; src_a = 32'd0; src_b = 32'd5;    // cycle 0
    next_cyc(); start = 1'b0;                                            // PREP
    next_cyc(); cancel = 1'b1;                                           // FIX
    next_cyc(); cancel = 1'b0;
    repeat (2) next_cyc();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != d0 || hi_out !== 32'd1 || lo_out !== 32'h23456780) begin
      n_err++; $display("FAIL cancel_fix got busy=%b dones=%0d data=%h_%h want 0/%0d 00000001_23456780",
                        busy, done_cnt, hi_out, lo_out, d0);
    end
    next_cyc(); start = 1'b1; op = 2'd0; src_a = 32'd0; src_b = 32'd5;    // cycle 0
    next_cyc(); start = 1'b0;
    next_cyc();
    next_cyc(); cancel = 1'b1;                                           // cycle 3 = DONE
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || hilo_we !== 2'b11 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL cancel_in_done got done=%b we=%b data=%h_%h want 1/11 0_0",
                        done, hilo_we, hi_out, lo_out);
    end
    next_cyc(); cancel = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL after_done got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo; logic [1:0] we; int lat, sbad; logic tb;
    lat = -1;
    next_cyc(); start = 1'b1; op = 2'd1; src_a = 32'h10000; src_b = 32'h10000;
    next_cyc(); start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = c; break; end
      next_cyc();
    end
    // request presented only during DONE must be dropped
    start = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5;
    next_cyc(); start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lat != 35 || busy !== 1'b0) begin
      n_err++; $display("FAIL start_in_done got lat=%0d busy=%b want 35/0", lat, busy);
    end
    repeat (3) next_cyc();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || hi_out !== 32'd1 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL result_hold got busy=%b data=%h_%h want 0 00000001_0", busy, hi_out, lo_out);
    end
    next_cyc();
    do_op(2'd0, 32'd5, 32'd5, hi, lo, we, lat, sbad, tb);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd25 || lat != 35 || tb !== 1'b0) begin
      n_err++; $display("FAIL next_op got %h_%h lat=%0d tail=%b want 0_19 35 0", hi, lo, lat, tb);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] hi, lo, eh, el; logic [1:0] we; int lat, sbad, d0; logic tb;
    next_cyc(); start = 1'b1; op = 2'd2; src_a = -32'sd100; src_b = 32'd3;
    next_cyc(); start = 1'b0;
    repeat (19) next_cyc();                                              // cycle 20
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, stall, done, hilo_we} !== 5'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      n_err++; $display("FAIL async_reset got ctrl=%b data=%h_%h want 00000 0_0",
                        {busy, stall, done, hilo_we}, hi_out, lo_out);
    end
    next_cyc(); next_cyc(); reset = 1'b1;
    repeat (40) next_cyc();
    @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_drop got dones=%0d busy=%b want %0d/0", done_cnt, busy, d0);
    end
    next_cyc();
    do_op(2'd2, -32'sd100, 32'd3, hi, lo, we, lat, sbad, tb);
    ref_op(2'd2, -32'sd100, 32'd3, eh, el);
    n_cmp++;
    if (hi !== eh || lo !== el || lat != 35) begin
      n_err++; $display("FAIL post_reset_op got %h_%h lat=%0d want %h_%h 35", hi, lo, lat, eh, el);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(1, 100));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] hi, lo, eh, el, a, b; logic [1:0] we, o; int lat, sbad; logic tb;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3)); a = pick(); b = pick();
      ref_op(o, a, b, eh, el);
      next_cyc();
      do_op(o, a, b, hi, lo, we, lat, sbad, tb);
      n_cmp++;
      if (hi !== eh || lo !== el) begin
        n_err++; $display("FAIL rand%0d op%0d %h,%h got %h_%h want %h_%h", i, o, a, b, hi, lo, eh, el);
      end
      n_cmp++;
      if (lat != ref_lat(o, a, b) || we !== 2'b11 || tb !== 1'b0 || sbad != 0) begin
        n_err++; $display("FAIL rand%0d timing got lat=%0d we=%b tail=%b stall_bad=%0d want %0d/11/0/0",
                          i, lat, we, tb, sbad, ref_lat(o, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cancel();
    test_cancel_fix_done();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
